// File: rtl/regfile_mp.sv
// regfile_mp: parametrised decode-stage register file.
// Two registered read ports, one write port, hardwired zero register and a
// post-reset clear sequencer that zeroes every entry before normal operation.
//
// Optional build macro: RF_BYPASS_EN
//   defined   -> a same-cycle write to the index being read is forwarded
//                (write-first)
//   undefined -> the read returns the pre-write array value (read-first)
//
// State table
//   state | meaning
//   CLEAR | sequencer writes 0 to one entry per clock, reads held at 0
//   RUN   | normal read/write operation, init_done high

`ifndef WORD
`define WORD 64
`endif

module regfile_mp #(
    parameter int WIDTH    = `WORD,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] read_register1,
    input  logic [ADDR_W-1:0] read_register2,
    input  logic [ADDR_W-1:0] write_register,
    input  logic [WIDTH-1:0]  write_data,
    input  logic              reg_write,
    output logic [WIDTH-1:0]  read_data1,
    output logic [WIDTH-1:0]  read_data2,
    output logic              init_done
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Index limits are widened by one bit so that DEPTH == 2**ADDR_W and the
    // "disabled" zero register value ZERO_REG == DEPTH are representable.
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   ZERO_X   = (ADDR_W+1)'(ZERO_REG);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_clear_ptr;
    logic              r_init_done;
    logic [WIDTH-1:0]  r_rd1;
    logic [WIDTH-1:0]  r_rd2;
    logic [WIDTH-1:0]  r_mem [DEPTH];

    logic              w_wr_valid;
    logic              w_rd1_valid;
    logic              w_rd2_valid;
    logic              w_run_wr;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [WIDTH-1:0]  w_mem_data;
    logic [WIDTH-1:0]  w_rd1_next;
    logic [WIDTH-1:0]  w_rd2_next;

    // An index is usable only if it is inside the array and is not the zero register.
    always_comb begin
        w_wr_valid  = ({1'b0, write_register} < DEPTH_X) && ({1'b0, write_register} != ZERO_X);
        w_rd1_valid = ({1'b0, read_register1} < DEPTH_X) && ({1'b0, read_register1} != ZERO_X);
        w_rd2_valid = ({1'b0, read_register2} < DEPTH_X) && ({1'b0, read_register2} != ZERO_X);
        w_run_wr    = reg_write && w_wr_valid && (r_state == RUN);
    end

    // Single array write port shared by the clear sequencer and the WB write;
    // reset gates it so a write coinciding with reset assertion is lost.
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = write_register;
        w_mem_data = write_data;
        if (!reset) begin
            if (r_state == CLEAR) begin
                w_mem_we   = 1'b1;
                w_mem_addr = r_clear_ptr;
                w_mem_data = '0;
            end else if (w_run_wr) begin
                w_mem_we = 1'b1;
            end
        end
    end

    // Array storage: no reset, contents are established by the clear sequencer.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    // Next read data per port, with optional same-cycle write forwarding.
    always_comb begin
        w_rd1_next = '0;
        w_rd2_next = '0;
        if (w_rd1_valid) begin
            w_rd1_next = r_mem[read_register1];
`ifdef RF_BYPASS_EN
            if (w_run_wr && (write_register == read_register1)) begin
                w_rd1_next = write_data;
            end
`endif
        end
        if (w_rd2_valid) begin
            w_rd2_next = r_mem[read_register2];
`ifdef RF_BYPASS_EN
            if (w_run_wr && (write_register == read_register2)) begin
                w_rd2_next = write_data;
            end
`endif
        end
    end

    // Sequencer FSM: clear every entry after reset, then serve reads until next reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= CLEAR;
            r_clear_ptr <= '0;
            r_init_done <= 1'b0;
            r_rd1       <= '0;
            r_rd2       <= '0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_rd1       <= '0;
                    r_rd2       <= '0;
                    r_clear_ptr <= r_clear_ptr + ADDR_W'(1);
                    if (r_clear_ptr == LAST_PTR) begin
                        r_state     <= RUN;
                        r_init_done <= 1'b1;
                    end
                end
                RUN: begin
                    r_rd1 <= w_rd1_next;
                    r_rd2 <= w_rd2_next;
                end
                default: begin
                    r_state <= CLEAR;
                end
            endcase
        end
    end

    assign read_data1 = r_rd1;
    assign read_data2 = r_rd2;
    assign init_done  = r_init_done;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp. Two instances share stimulus:
// dut_a with DEPTH=32 and dut_b with DEPTH=24 (indices 24..31 out of range).
// Expected values come from a simple array model of the register file rules.

module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rr1, rr2, wa;
    logic [63:0] wd;
    logic        we;
    logic [63:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic        done_a, done_b;

    always #5 clk = ~clk;

    regfile_mp #(.WIDTH(64), .DEPTH(32), .ADDR_W(5), .ZERO_REG(31)) dut_a (
        .clk(clk), .reset(reset),
        .read_register1(rr1), .read_register2(rr2),
        .write_register(wa), .write_data(wd), .reg_write(we),
        .read_data1(rd1_a), .read_data2(rd2_a), .init_done(done_a)
    );

    regfile_mp #(.WIDTH(64), .DEPTH(24), .ADDR_W(5), .ZERO_REG(31)) dut_b (
        .clk(clk), .reset(reset),
        .read_register1(rr1), .read_register2(rr2),
        .write_register(wa), .write_data(wd), .reg_write(we),
        .read_data1(rd1_b), .read_data2(rd2_b), .init_done(done_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: per-instance contents and edges seen since reset release.
    logic [63:0] mem [2][32];
    int          dep [2] = '{32, 24};
    int          cnt [2];
    logic [63:0] e1 [2];
    logic [63:0] e2 [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_rd(int d, logic [4:0] a);
        if (cnt[d] < dep[d]) return 64'd0;
        if (int'(a) >= dep[d] || a == 5'd31) return 64'd0;
`ifdef RF_BYPASS_EN
        if (we && wa == a) return wd;
`endif
        return mem[d][a];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            cnt[d] = 0;
            for (int i = 0; i < 32; i++) mem[d][i] = 64'd0;
        end
    endtask

    task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic w,
                         input logic [4:0] a, input logic [63:0] dat);
        rr1 = r1; rr2 = r2; we = w; wa = a; wd = dat;
    endtask

    // One clock: predict, clock, update model, check both instances.
    task automatic step(input string tag);
        for (int d = 0; d < 2; d++) begin
            e1[d] = exp_rd(d, rr1);
            e2[d] = exp_rd(d, rr2);
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (cnt[d] >= dep[d]) begin
                if (we && int'(wa) < dep[d] && wa != 5'd31) mem[d][wa] = wd;
            end else begin
                cnt[d]++;
            end
        end
        #1;
        check({tag, " rd1_a"}, rd1_a, e1[0]);
        check({tag, " rd2_a"}, rd2_a, e2[0]);
        check({tag, " rd1_b"}, rd1_b, e1[1]);
        check({tag, " rd2_b"}, rd2_b, e2[1]);
        check({tag, " done_a"}, 64'(done_a), 64'(cnt[0] >= dep[0]));
        check({tag, " done_b"}, 64'(done_b), 64'(cnt[1] >= dep[1]));
    endtask

    task automatic check_zero(input string tag);
        check({tag, " rd1_a"}, rd1_a, 64'd0);
        check({tag, " rd2_a"}, rd2_a, 64'd0);
        check({tag, " rd1_b"}, rd1_b, 64'd0);
        check({tag, " rd2_b"}, rd2_b, 64'd0);
        check({tag, " done_a"}, 64'(done_a), 64'd0);
        check({tag, " done_b"}, 64'(done_b), 64'd0);
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 32; i++) begin
            drive(5'(i), 5'(31 - i), 1'b0, 5'd0, 64'd0);
            step(tag);
        end
    endtask

    initial begin
        logic [4:0]  ra;
        logic [63:0] rdat;

        // Reset state
        reset = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 5'd0, 64'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // Clear phase: dropped write to index 3 at cycle 10, random reads;
        // dut_b enters RUN after 24 edges and takes random writes.
        for (int c = 0; c < 32; c++) begin
            if (c == 10) drive(5'($urandom_range(31)), 5'($urandom_range(31)), 1'b1, 5'd3, 64'h55);
            else drive(5'($urandom_range(31)), 5'($urandom_range(31)),
                       (c >= 24) ? 1'($urandom_range(1)) : 1'b0,
                       5'($urandom_range(31)), {$urandom(), $urandom()});
            step("clear");
        end
        check("init_done after 32", 64'(done_a), 64'd1);
        sweep("sweep0");
        drive(5'd3, 5'd3, 1'b0, 5'd0, 64'd0);
        step("idx3 dropped");
        check("idx3 const", rd1_a, 64'd0);

        // Write then read same index on both ports
        drive(5'd0, 5'd1, 1'b1, 5'd5, 64'hDEAD_BEEF_0000_0005);
        step("wr5");
        drive(5'd5, 5'd5, 1'b0, 5'd0, 64'd0);
        step("rd5");
        check("rd5 p1 const", rd1_a, 64'hDEAD_BEEF_0000_0005);
        check("rd5 p2 const", rd2_a, 64'hDEAD_BEEF_0000_0005);

        // Zero register ignores writes
        drive(5'd0, 5'd0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
        step("wr31");
        drive(5'd31, 5'd31, 1'b0, 5'd0, 64'd0);
        step("rd31");
        check("rd31 const", rd1_a, 64'd0);

        // Index 28: valid on dut_a, out of range on dut_b
        drive(5'd0, 5'd0, 1'b1, 5'd28, 64'h2828);
        step("wr28");
        drive(5'd28, 5'd28, 1'b0, 5'd0, 64'd0);
        step("rd28");
        check("rd28 b const", rd1_b, 64'd0);
        check("rd28 a const", rd1_a, 64'h2828);

        // Same-cycle read and write of index 7
        drive(5'd0, 5'd0, 1'b1, 5'd7, 64'hAAAA);
        step("wr7 old");
        drive(5'd7, 5'd0, 1'b1, 5'd7, 64'h1234);
        step("wr7 same");
`ifdef RF_BYPASS_EN
        check("rd7 same const", rd1_a, 64'h1234);
`else
        check("rd7 same const", rd1_a, 64'hAAAA);
`endif
        drive(5'd7, 5'd7, 1'b0, 5'd0, 64'd0);
        step("rd7 next");
        check("rd7 next const", rd1_a, 64'h1234);

        // Randomized traffic with forced collisions
        for (int n = 0; n < 400; n++) begin
            ra   = 5'($urandom_range(31));
            rdat = {$urandom(), $urandom()};
            drive(5'($urandom_range(31)), 5'($urandom_range(31)), 1'($urandom_range(1)), ra, rdat);
            if ($urandom_range(3) == 0) rr1 = ra;
            if ($urandom_range(3) == 0) rr2 = rr1;
            step("rand");
        end
        sweep("sweep1");

        // Mid-operation reset
        drive(5'd9, 5'd9, 1'b1, 5'd9, 64'h77);
        step("wr9");
        drive(5'd9, 5'd9, 1'b0, 5'd0, 64'd0);
        step("rd9");
        check("rd9 const", rd1_a, 64'h77);
        #2;
        drive(5'd9, 5'd9, 1'b1, 5'd9, 64'h99);
        reset = 1'b1;
        #1;
        check_zero("async reset");
        model_reset();
        @(posedge clk);
        #1;
        check_zero("reset held");
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 32; c++) begin
            drive(5'd9, 5'($urandom_range(31)), 1'b0, 5'd0, 64'd0);
            step("reclear");
        end
        check("init_done again", 64'(done_a), 64'd1);
        drive(5'd9, 5'd9, 1'b0, 5'd0, 64'd0);
        step("rd9 after reset");
        check("rd9 reset const", rd1_a, 64'd0);
        sweep("sweep2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the decode-stage register file.
- Single clock; two registered read ports and one write port.
- Configurable width and depth, with a hardwired zero register (XZR).
- A post-reset clear sequencer guarantees known contents, and an optional write-to-read bypass is available.
- Sits in the decode stage; feeds operands to execute and accepts writeback from the WB stage.

Parameters:
- WIDTH, 64 (`WORD): data width in bits.
- DEPTH, 32: number of registers.
- ADDR_W, 5: register index width. Must satisfy 2**ADDR_W >= DEPTH.
- ZERO_REG, 31: index that always reads 0 and ignores writes. Set it to DEPTH to disable this behaviour.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- read_register1  input  ADDR_W  index for read port 1.
- read_register2  input  ADDR_W  index for read port 2.
- write_register  input  ADDR_W  write index.
- write_data  input  WIDTH  write data.
- reg_write  input  1  write enable.
- read_data1  output  WIDTH  registered read data, port 1.
- read_data2  output  WIDTH  registered read data, port 2.
- init_done  output  1  high once the clear sequence has completed.

Behaviour:
- Reset:
  - Asynchronous and active-high.
  - While reset is high: read_data1 = 0, read_data2 = 0, init_done = 0, state = CLEAR, clear_ptr = 0.
  - Array contents are not reset directly; they are cleared by the sequencer.
- FSM states are CLEAR and RUN.
- CLEAR:
  - Each clock writes 0 to rmem[clear_ptr], then clear_ptr increments.
  - When clear_ptr == DEPTH-1 is written, the next state is RUN and init_done = 1 from that edge onward.
  - CLEAR therefore lasts exactly DEPTH cycles after reset deassertion.
  - reg_write is ignored; the write is dropped, not queued.
  - read_data1/2 are held at 0.
- RUN:
  - Read latency is 1 cycle: at the rising edge, read_dataN <= rmem[read_registerN].
  - Write: at the rising edge, if reg_write and write_register != ZERO_REG and write_register < DEPTH, then rmem[write_register] <= write_data.
  - Zero register: a read of ZERO_REG returns 0 regardless of array content.
  - Out of range: a read index >= DEPTH returns 0. A write index >= DEPTH is discarded.
  - Both ports may read the same index in the same cycle; both return identical data.
- Same-cycle read and write to the same index: governed by RF_BYPASS_EN (see Optional Feature).
- Reset mid-operation:
  - Asserting reset in either state immediately forces the reset values.
  - Any write on that edge is lost.
  - After deassertion, a full DEPTH-cycle CLEAR runs again.
- RUN stays RUN until the next reset; there is no other exit.
- No X on outputs after reset, under any input.

Optional Feature:
- Macro name: RF_BYPASS_EN.
- Defined:
  - If reg_write is high, write_register == read_registerN, and that index is neither ZERO_REG nor out of range, then read_dataN <= write_data at the same edge (write-first).
  - Applies to each port independently.
- Undefined:
  - read_dataN gets the pre-write array value (read-first).
  - The new value is visible on a read issued in the following cycle.

Test Plan:
- Reset, then poll init_done with DEPTH=32:
  - init_done rises exactly 32 clocks after reset deassertion.
  - Reading every index 0..31 then returns 0 on both ports.
- In RUN:
  - Write 0xDEAD_BEEF_0000_0005 to index 5, then read index 5 on port 1 and index 5 on port 2 in the next cycle.
  - Both ports show 0xDEAD_BEEF_0000_0005 one clock later.
- Write 0xFFFF_FFFF_FFFF_FFFF to index 31 (ZERO_REG), then read 31 -> 0.
  - Also, with DEPTH=24, write to index 28 then read 28 -> 0, and no other entry changes.
- Same-cycle write of 0x1234 to index 7 with read_register1=7, old value 0xAAAA:
  - With RF_BYPASS_EN: read_data1 = 0x1234.
  - Without RF_BYPASS_EN: read_data1 = 0xAAAA, and the next-cycle read returns 0x1234.
- Assert reg_write to index 3 with data 0x55 during CLEAR cycle 10:
  - After init_done, reading 3 -> 0 (write dropped).
  - read_data1/2 remain 0 throughout CLEAR.
- Write 0x77 to index 9, then assert reset asynchronously mid-cycle:
  - Outputs go to 0 immediately and init_done drops to 0.
  - After 32 clocks init_done = 1 again, and reading 9 -> 0.
